intc_nch: RTL

//  Parametrised N-source interrupt controller; successor to the fixed 4-source intc.

---
 rtl/intc_pkg.sv | 11 +
 rtl/intc_prio_enc.sv | 25 ++
 rtl/intc_nch.sv | 105 ++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared types and helpers for the N-source interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    // Source index width: ceil(log2(n_src)), never narrower than one bit.
    function automatic int id_width(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational find-first-set: reports whether any request is active and the lowest active index.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves a latch.
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_nch.sv
// N-source interrupt controller: sticky pending latches, fixed priority, irq/iack handshake FSM.
// Optional per-source mask port enabled by defining INTC_MASK_EN.
module intc_nch
    import intc_pkg::*;
#(
    parameter int                N_SRC      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0100),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0010),
    localparam int               ID_W       = id_width(N_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  done,
    input  logic              iack,
    output logic              irq,
    output logic [ADDR_W-1:0] PC_handler,
    output logic [ID_W-1:0]   irq_id,
    output logic [N_SRC-1:0]  pending
`ifdef INTC_MASK_EN
    ,
    input  logic [N_SRC-1:0]  mask
`endif
);

    state_t              r_state;
    logic                r_irq;
    logic [ID_W-1:0]     r_irq_id;
    logic [ADDR_W-1:0]   r_pc;
    logic [N_SRC-1:0]    r_pending;

    logic [N_SRC-1:0]    w_eligible;
    logic [N_SRC-1:0]    w_clr;
    logic                w_win_valid;
    logic [ID_W-1:0]     w_win_idx;
    logic [ADDR_W-1:0]   w_vec;

`ifdef INTC_MASK_EN
    // Masked sources keep latching but cannot win arbitration.
    assign w_eligible = r_pending & ~mask;
`else
    assign w_eligible = r_pending;
`endif

    intc_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .i_req   (w_eligible),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    // Handler address wraps modulo 2^ADDR_W by truncation to the vector width.
    assign w_vec = VEC_BASE + ADDR_W'(w_win_idx) * VEC_STRIDE;
    assign w_clr = (r_state == REQ && iack) ? (N_SRC'(1) << r_irq_id) : '0;

    // A new request in the acknowledge cycle re-sets the bit being cleared.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
            r_pc     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_irq_id <= w_win_idx;
                        r_pc     <= w_vec;
                        r_irq    <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (iack) begin
                        r_irq   <= 1'b0;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!iack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign irq        = r_irq;
    assign irq_id     = r_irq_id;
    assign PC_handler = r_pc;
    assign pending    = r_pending;

endmodule
